// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage for the 16-bit single-cycle datapath.
// Owns the PC, reads instruction memory through a request/done handshake and
// holds one registered instruction for decode. Stops on HALT or on a fault.
// Optional feature: define FETCH_ICOUNT_EN to build the consumed-instruction
// counter; otherwise icount is tied to zero.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        imem_stall,
    input  logic        imem_done,
    input  logic [15:0] imem_data,
    input  logic        imem_err,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    output logic [15:0] Instruction,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    output logic        halted,
    output logic        err,
    output logic [15:0] icount
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_VALID,
        S_HALTED
    } state_e;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    state_e      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic        valid_q;
    logic        halted_q;
    logic        err_q;
    logic        rd_q;

    logic        consume;
    logic        is_halt;
    logic        bad_target;
    logic [15:0] pc_d;

    // Decode-side consume qualifiers and the next sequential/redirected PC.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output
        // unconditionally, so no latch can be inferred.
        consume    = (state_q == S_VALID) && !stall_in;
        is_halt    = (instr_q[15:11] == 5'b00000);
        bad_target = redirect && redirect_pc[0];
        pc_d       = redirect ? redirect_pc : (pc_q + 16'd2);
    end

    // Fetch FSM with registered outputs; redirect is only looked at on consume.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b1;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!imem_stall) begin
                        state_q <= S_WAIT;
                        rd_q    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_done) begin
                        if (imem_err) begin
                            err_q    <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= S_HALTED;
                        end else begin
                            instr_q <= imem_data;
                            valid_q <= 1'b1;
                            state_q <= S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (!stall_in) begin
                        valid_q <= 1'b0;
                        if (is_halt) begin
                            // HALT never uses the redirect target, so it wins.
                            halted_q <= 1'b1;
                            state_q  <= S_HALTED;
                        end else if (bad_target) begin
                            err_q    <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= S_HALTED;
                        end else begin
                            pc_q    <= pc_d;
                            rd_q    <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_HALTED;
                end
            endcase
        end
    end

`ifdef FETCH_ICOUNT_EN
    logic [15:0] icount_q;

    // Count consumed instructions, including HALT but not faulting redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icount_q <= 16'h0000;
        end else if (consume && (is_halt || !bad_target)) begin
            icount_q <= icount_q + 16'd1;
        end
    end

    assign icount = icount_q;
`else
    assign icount = 16'h0000;
`endif

    // Request is suppressed while reset is held so memory never sees a stray read.
    assign imem_rd     = rd_q & ~rst;
    assign imem_addr   = pc_q;
    assign Instruction = instr_q;
    assign pc          = pc_q;
    assign pc_plus2    = pc_q + 16'd2;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized transaction-level checks of
// fetch_stage against a per-instruction reference model.
module tb_fetch_stage;

    localparam logic [15:0] RESET_PC = 16'h0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_stall = 1'b0;
    logic        imem_done = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_err = 1'b0;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] Instruction;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        halted;
    logic        err;
    logic [15:0] icount;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_stall  (imem_stall),
        .imem_done   (imem_done),
        .imem_data   (imem_data),
        .imem_err    (imem_err),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .Instruction (Instruction),
        .pc          (pc),
        .pc_plus2    (pc_plus2),
        .instr_valid (instr_valid),
        .halted      (halted),
        .err         (err),
        .icount      (icount)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: architectural view updated once per instruction.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_icount;
    logic        m_halted;
    logic        m_err;

    function automatic logic [15:0] exp_icount();
`ifdef FETCH_ICOUNT_EN
        return m_icount;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic exp_valid, input logic exp_rd);
        chk({tag, ".pc"},          pc,          m_pc);
        chk({tag, ".pc_plus2"},    pc_plus2,    m_pc + 16'd2);
        chk({tag, ".imem_addr"},   imem_addr,   m_pc);
        chk({tag, ".Instruction"}, Instruction, m_instr);
        chk({tag, ".instr_valid"}, {15'd0, instr_valid}, {15'd0, exp_valid});
        chk({tag, ".imem_rd"},     {15'd0, imem_rd},     {15'd0, exp_rd});
        chk({tag, ".halted"},      {15'd0, halted},      {15'd0, m_halted});
        chk({tag, ".err"},         {15'd0, err},         {15'd0, m_err});
        chk({tag, ".icount"},      icount,      exp_icount());
    endtask

    task automatic clear_inputs();
        stall_in    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_stall  = 1'b0;
        imem_done   = 1'b0;
        imem_data   = 16'h0000;
        imem_err    = 1'b0;
    endtask

    // Called at a falling edge; asserts reset between clock edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        m_pc     = RESET_PC;
        m_instr  = 16'h0800;
        m_icount = 16'h0000;
        m_halted = 1'b0;
        m_err    = 1'b0;
        check_state("reset_async", 1'b0, 1'b0);
        clear_inputs();
        @(negedge clk);
        check_state("reset_held", 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_state("reset_release", 1'b0, 1'b1);
    endtask

    // One instruction end to end: memory stall cycles, response, decode
    // stall cycles, then the consume with the given redirect.
    task automatic fetch_one(input int mstall, input logic [15:0] data, input logic merr,
                             input int dstall, input logic redir, input logic [15:0] rpc);
        check_state("fetch", 1'b0, 1'b1);
        imem_stall = 1'b1;
        for (int i = 0; i < mstall; i++) begin
            imem_done   = 1'b1;
            imem_data   = ~data;
            redirect    = 1'b1;
            redirect_pc = 16'h0AA0;
            @(negedge clk);
            check_state("fetch_stall", 1'b0, 1'b1);
        end
        imem_stall = 1'b0;
        imem_done  = 1'b0;
        redirect   = 1'b0;
        @(negedge clk);
        check_state("wait", 1'b0, 1'b0);
        imem_done = 1'b1;
        imem_data = data;
        imem_err  = merr;
        @(negedge clk);
        imem_done = 1'b0;
        imem_err  = 1'b0;
        if (merr) begin
            m_err    = 1'b1;
            m_halted = 1'b1;
            check_state("mem_fault", 1'b0, 1'b0);
            return;
        end
        m_instr = data;
        check_state("valid", 1'b1, 1'b0);
        stall_in = 1'b1;
        for (int i = 0; i < dstall; i++) begin
            redirect    = 1'b1;
            redirect_pc = 16'h0AA0;
            imem_done   = 1'b1;
            @(negedge clk);
            check_state("decode_stall", 1'b1, 1'b0);
        end
        imem_done   = 1'b0;
        stall_in    = 1'b0;
        redirect    = redir;
        redirect_pc = rpc;
        @(negedge clk);
        redirect = 1'b0;
        if (data[15:11] == 5'b00000) begin
            m_halted = 1'b1;
            m_icount = m_icount + 16'd1;
        end else if (redir && rpc[0]) begin
            m_err    = 1'b1;
            m_halted = 1'b1;
        end else begin
            m_pc     = redir ? rpc : m_pc + 16'd2;
            m_icount = m_icount + 16'd1;
        end
        check_state("consume", 1'b0, !m_halted);
    endtask

    // Once stopped, nothing but reset may change the block.
    task automatic halted_hold(input int n);
        for (int i = 0; i < n; i++) begin
            imem_done   = 1'b1;
            imem_data   = 16'hFFFF;
            redirect    = 1'b1;
            redirect_pc = 16'h0002;
            stall_in    = 1'b0;
            @(negedge clk);
            check_state("halted_hold", 1'b0, 1'b0);
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r_data;
        logic [15:0] r_pc;
        logic        r_redir;

        clear_inputs();
        @(negedge clk);
        do_reset();

        // Jump from the reset vector to 0x0000, then straight-line code.
        fetch_one(0, 16'h5000, 1'b0, 0, 1'b1, 16'h0000);
        fetch_one(0, 16'h4000, 1'b0, 0, 1'b0, 16'h0000);
        fetch_one(0, 16'h4100, 1'b0, 0, 1'b0, 16'h0000);
        fetch_one(0, 16'h4200, 1'b0, 0, 1'b1, 16'h0040);

        // Back-pressure from memory and from decode.
        fetch_one(4, 16'h4300, 1'b0, 3, 1'b0, 16'h0000);

        // PC wrap at the top of the address space.
        fetch_one(0, 16'h4400, 1'b0, 0, 1'b1, 16'hFFFE);
        fetch_one(0, 16'h4500, 1'b0, 0, 1'b0, 16'h0000);
        chk("wrap_pc", pc, 16'h0000);

        // Randomized non-HALT traffic with even redirect targets.
        for (int k = 0; k < 16; k++) begin
            r_data  = 16'($urandom);
            r_data[15:11] = 5'($urandom_range(1, 31));
            r_pc    = 16'($urandom) & 16'hFFFE;
            r_redir = 1'($urandom_range(0, 1));
            fetch_one(int'($urandom_range(0, 2)), r_data, 1'b0,
                      int'($urandom_range(0, 2)), r_redir, r_pc);
        end

        // HALT at 0x0010.
        fetch_one(0, 16'h4600, 1'b0, 0, 1'b1, 16'h0010);
        fetch_one(1, 16'h0000, 1'b0, 1, 1'b0, 16'h0000);
        chk("halt_pc", pc, 16'h0010);
        halted_hold(5);

        // Memory fault: Instruction keeps the reset NOP.
        do_reset();
        fetch_one(1, 16'h4700, 1'b1, 0, 1'b0, 16'h0000);
        chk("fault_instr", Instruction, 16'h0800);
        halted_hold(3);

        // Odd redirect target on consume.
        do_reset();
        fetch_one(0, 16'h4800, 1'b0, 0, 1'b1, 16'h0021);
        chk("bad_target_pc", pc, RESET_PC);
        halted_hold(3);

        // Asynchronous reset while waiting for memory.
        do_reset();
        fetch_one(0, 16'h4900, 1'b0, 0, 1'b0, 16'h0000);
        imem_stall = 1'b0;
        @(negedge clk);
        check_state("pre_reset_wait", 1'b0, 1'b0);
        do_reset();
        fetch_one(0, 16'h4A00, 1'b0, 1, 1'b0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the 16-bit single-cycle datapath. Owns the PC register, issues instruction-memory reads through a request/done handshake, and presents one registered instruction word plus PC and PC+2 to the decode stage. Decode consumes the instruction and returns branch/jump redirects. The block stops permanently on HALT or on a fetch error.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; must be even.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- stall_in  input  1  decode not ready; the held instruction is not consumed
- redirect  input  1  take redirect_pc as next PC; sampled only on consume
- redirect_pc  input  16  branch/jump target from decode/ALU
- imem_stall  input  1  memory cannot accept the request this cycle
- imem_done  input  1  read data valid on imem_data
- imem_data  input  16  instruction word from memory
- imem_err  input  1  memory fault; sampled with imem_done
- imem_rd  output  1  read request
- imem_addr  output  16  read address (= pc)
- Instruction  output  16  registered instruction to decode
- pc  output  16  address of Instruction
- pc_plus2  output  16  pc + 2, modulo 2^16
- instr_valid  output  1  Instruction is valid for decode
- halted  output  1  sticky; HALT consumed or error
- err  output  1  sticky fetch error
- icount  output  16  consumed-instruction counter (see Configuration)

## Operation
- States: FETCH, WAIT, VALID, HALTED. Encoding is free; the state register is reset asynchronously.
- FETCH:
  - imem_rd = 1, imem_addr = pc.
  - imem_stall = 1: remain in FETCH.
  - imem_stall = 0: the request is accepted; go to WAIT.
- WAIT:
  - imem_rd = 0; imem_done is sampled only in this state.
  - imem_done = 1 and imem_err = 0: Instruction <= imem_data; go to VALID.
  - imem_done = 1 and imem_err = 1: err <= 1, halted <= 1; go to HALTED. Instruction is not updated.
- VALID:
  - instr_valid = 1.
  - Consume occurs when stall_in = 0.
  - On consume of HALT (Instruction[15:11] = 5'b00000): halted <= 1; go to HALTED; pc holds.
  - On consume of any other instruction: pc <= redirect ? redirect_pc : pc + 2; go to FETCH.
  - Consume with redirect = 1 and redirect_pc[0] = 1: err <= 1, halted <= 1; go to HALTED; pc holds.
- HALTED: imem_rd = 0, instr_valid = 0. Only rst exits this state.
- PC arithmetic is 16-bit and wraps: 16'hFFFE + 2 = 16'h0000.
- pc_plus2 is combinational from pc.

## Timing
- Reset values:
  - state = FETCH, pc = RESET_PC, Instruction = 16'h0800 (NOP)
  - instr_valid = 0, halted = 0, err = 0, icount = 0
- imem_rd is gated by ~rst, so no request is issued while reset is asserted.
- Minimum cycle sequence per instruction, with no stalls:
  - cycle N: FETCH, request accepted
  - cycle N+1: WAIT, imem_done = 1
  - cycle N+2: VALID, consumed
  - cycle N+3: FETCH for the next PC
  - This gives 3 cycles per instruction.
- Fetch latency: instr_valid rises the cycle after imem_done is sampled.
- imem_done or imem_err asserted outside WAIT is ignored.
- redirect and redirect_pc are ignored outside a consume cycle.
- Reset mid-operation (any state): immediate return to reset values. The memory shares rst, so no stale imem_done arrives after reset.
- imem_stall held indefinitely: the block stays in FETCH with a stable imem_addr.

## Configuration
- FETCH_ICOUNT_EN defined:
  - icount increments by 1 (wrapping) on every consume, including the HALT consume.
  - icount is not incremented on error-terminated consumes.
- FETCH_ICOUNT_EN undefined:
  - No counter register is built; icount is tied to 16'h0000.

## Test plan
- Reset then straight-line fetch: memory returns 16'h4000 at 0x0000 and 16'h4100 at 0x0002, done one cycle after accept, stall_in = 0.
  - Required: imem_addr goes 0x0000, then 0x0002, then 0x0004; instr_valid pulses once per 3 cycles; pc_plus2 = pc + 2.
- Redirect: consume the word at 0x0002 with redirect = 1, redirect_pc = 0x0040.
  - Required: next imem_addr = 0x0040; redirect asserted outside VALID has no effect.
- Back-pressure: imem_stall = 1 for 4 cycles, then stall_in = 1 for 3 cycles in VALID.
  - Required: imem_addr stable throughout; Instruction and pc stable; exactly one consume.
- HALT: memory returns 16'h0000 at 0x0010.
  - Required: after consume, halted = 1, instr_valid = 0, pc = 0x0010, imem_rd = 0 forever until rst.
  - With FETCH_ICOUNT_EN: icount counts the HALT.
- Errors, as two separate runs:
  - imem_err = 1 with imem_done → err = 1, halted = 1, Instruction unchanged.
  - redirect_pc = 0x0021 on consume → err = 1, halted = 1, pc unchanged.
- Asynchronous reset asserted mid-WAIT, with RESET_PC = 0x0100.
  - Required: outputs return to reset values within the same cycle with no clock edge needed; fetch restarts at 0x0100.
